l2_msg_injector: RTL

L2_MSG_INJECTOR -- requirements
Module: l2_msg_injector

---
 rtl/l2_msg_injector.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/l2_msg_injector.sv
// Serialises abstract L2 messages into HDR / ADDR / optional DATA flits on the L2 NoC input,
// counting completed messages and flagging flits that stay stalled for too long.
module l2_msg_injector #(
    parameter int MAX_STALL = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_type,
    input  logic [5:0]  in_source,
    input  logic [25:0] in_tag,
    input  logic [63:0] in_data,
    input  logic        in_has_data,
    output logic        noc_valid,
    input  logic        noc_ready,
    output logic [63:0] noc_data,
    output logic        busy,
    output logic [15:0] msg_count,
    output logic        stall_err
);

    localparam int             CW          = $clog2(MAX_STALL + 2);
    localparam logic [CW-1:0]  STALL_LIMIT = CW'(MAX_STALL);
    localparam logic [CW-1:0]  STALL_SAT   = CW'(MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_e;

    state_e        state_q;
    logic          in_ready_q;
    logic          noc_valid_q;
    logic [63:0]   noc_data_q;
    logic          busy_q;
    logic [15:0]   msg_count_q;
    logic          stall_err_q;
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] stall_cnt_d;
    logic [25:0]   tag_q;
    logic [63:0]   data_q;
    logic          has_data_q;

    function automatic logic [63:0] hdr_flit(input logic [7:0] msg_type,
                                              input logic [5:0] source,
                                              input logic       has_data);
        logic [7:0] len;
        len = has_data ? 8'd2 : 8'd1;
        return {34'd0, len, msg_type, source, 8'd0};
    endfunction

    function automatic logic [63:0] addr_flit(input logic [25:0] tag);
        return {24'd0, tag, 14'd0};
    endfunction

    // Message FSM with registered handshake and flit outputs.
    // Type and source are only needed for the header, so the header register itself holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            noc_valid_q <= 1'b0;
            noc_data_q  <= 64'd0;
            busy_q      <= 1'b0;
            msg_count_q <= 16'd0;
            tag_q       <= 26'd0;
            data_q      <= 64'd0;
            has_data_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        tag_q       <= in_tag;
                        data_q      <= in_data;
                        has_data_q  <= in_has_data;
                        noc_data_q  <= hdr_flit(in_type, in_source, in_has_data);
                        noc_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= HDR;
                    end else begin
                        // The cycle after a message completes is a recovery cycle with in_ready low.
                        in_ready_q  <= 1'b1;
                    end
                end
                HDR: begin
                    if (noc_ready) begin
                        noc_data_q <= addr_flit(tag_q);
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (noc_ready) begin
                        if (has_data_q) begin
                            noc_data_q <= data_q;
                            state_q    <= DATA;
                        end else begin
                            noc_data_q  <= 64'd0;
                            noc_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            msg_count_q <= msg_count_q + 16'd1;
                            state_q     <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (noc_ready) begin
                        noc_data_q  <= 64'd0;
                        noc_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        msg_count_q <= msg_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    noc_data_q  <= 64'd0;
                    noc_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Next stall count: saturating run length of stalled flit cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE) begin
            stall_cnt_d = {CW{1'b0}};
        end else if (noc_ready) begin
            stall_cnt_d = {CW{1'b0}};
        end else if (stall_cnt_q != STALL_SAT) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CW{1'b0}};
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_q | (stall_cnt_d > STALL_LIMIT);
        end
    end

    assign in_ready  = in_ready_q;
    assign noc_valid = noc_valid_q;
    assign noc_data  = noc_data_q;
    assign busy      = busy_q;
    assign msg_count = msg_count_q;
    assign stall_err = stall_err_q;

endmodule
